// File: rtl/rank_order_filter_if.sv
// Handshake bundle for the rank-order filter: window in, selected pixel out.
`timescale 1ns/1ps
interface rank_order_filter_if #(parameter int DATA_W = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [9*DATA_W-1:0]   px_in;
  logic [3:0]            rank_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_noisy;

  modport master (output in_valid, px_in, rank_sel, out_ready,
                  input  in_ready, out_valid, out_data, out_noisy);
  modport slave  (input  in_valid, px_in, rank_sel, out_ready,
                  output in_ready, out_valid, out_data, out_noisy);
endinterface

// File: rtl/rank_order_filter.sv
// Pipelined 3x3 rank-order filter: 9-round odd-even transposition sort, global stall.
// Define ADAPTIVE_SWITCH_EN for the adaptive switching-median output stage.
`timescale 1ns/1ps
module cmp_swap #(parameter int DATA_W = 8) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);
  // Strict compare so equal values never swap.
  assign lo = (a > b) ? b : a;
  assign hi = (a > b) ? a : b;
endmodule

module rank_order_filter #(parameter int DATA_W = 8) (
  input logic clk,
  input logic rst,
  rank_order_filter_if.slave bus
);
  localparam int STAGES = 9;
  typedef logic [8:0][DATA_W-1:0] win_t;

  win_t                   stg [STAGES:0];
  win_t                   nxt [1:STAGES];
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][3:0]   rank_pipe;
`ifdef ADAPTIVE_SWITCH_EN
  logic [STAGES:0][DATA_W-1:0] ctr_pipe;
`endif

  logic                   adv;
  logic                   out_valid_q;
  logic [DATA_W-1:0]      out_data_q;
  logic                   out_noisy_q;
  win_t                   srt;
  logic [DATA_W-1:0]      pick;
  logic [DATA_W-1:0]      data_c;
  logic                   noisy_c;

  // Everything advances together unless the output is held by the sink.
  assign adv          = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = adv;

  for (genvar s = 1; s <= STAGES; s++) begin : g_stg
    localparam int OFF = (s % 2 == 1) ? 0 : 1;
    for (genvar p = 0; p < 4; p++) begin : g_pair
      cmp_swap #(.DATA_W(DATA_W)) u_cx (
        .a  (stg[s-1][OFF+2*p]),
        .b  (stg[s-1][OFF+2*p+1]),
        .lo (nxt[s][OFF+2*p]),
        .hi (nxt[s][OFF+2*p+1])
      );
    end
    if (OFF == 0) begin : g_pass_hi
      assign nxt[s][8] = stg[s-1][8];
    end else begin : g_pass_lo
      assign nxt[s][0] = stg[s-1][0];
    end
  end

  assign srt  = stg[STAGES];
  assign pick = srt[rank_pipe[STAGES]];

`ifdef ADAPTIVE_SWITCH_EN
  // Only impulse pixels (centre at an extreme) get replaced.
  assign noisy_c = (ctr_pipe[STAGES] == srt[0]) || (ctr_pipe[STAGES] == srt[8]);
  assign data_c  = noisy_c ? pick : ctr_pipe[STAGES];
`else
  assign noisy_c = 1'b0;
  assign data_c  = pick;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe    <= '0;
      rank_pipe   <= '0;
      for (int s = 0; s <= STAGES; s++) stg[s] <= '0;
`ifdef ADAPTIVE_SWITCH_EN
      ctr_pipe    <= '0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_noisy_q <= 1'b0;
    end else if (adv) begin
      vld_pipe[0]  <= bus.in_valid;
      stg[0]       <= bus.px_in;
      rank_pipe[0] <= (bus.rank_sel > 4'd8) ? 4'd8 : bus.rank_sel;
`ifdef ADAPTIVE_SWITCH_EN
      ctr_pipe[0]  <= bus.px_in[4*DATA_W +: DATA_W];
`endif
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        stg[s]       <= nxt[s];
        rank_pipe[s] <= rank_pipe[s-1];
`ifdef ADAPTIVE_SWITCH_EN
        ctr_pipe[s]  <= ctr_pipe[s-1];
`endif
      end
      out_valid_q <= vld_pipe[STAGES];
      out_data_q  <= data_c;
      out_noisy_q <= noisy_c;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_noisy = out_noisy_q;
endmodule

// File: tb/tb_rank_order_filter.sv
// Scoreboard bench for rank_order_filter: 8-bit and 12-bit instances, table + sequences.
`timescale 1ns/1ps
module tb_rank_order_filter;
  localparam bit ADP =
`ifdef ADAPTIVE_SWITCH_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rank_order_filter_if #(.DATA_W(8))  b8();
  rank_order_filter_if #(.DATA_W(12)) b12();
  rank_order_filter #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  rank_order_filter #(.DATA_W(12)) dut12 (.clk(clk), .rst(rst), .bus(b12));

  typedef logic [8:0][15:0] win_t;
  typedef struct { logic [15:0] d; logic n; int acc; bit lat; } exp_t;
  typedef struct { win_t px; logic [3:0] r; logic [15:0] d; logic n; } vec_t;

  exp_t q8[$];
  exp_t q12[$];
  exp_t e8, e12;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic win_t mkw(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    win_t w;
    w[0] = 16'(a0); w[1] = 16'(a1); w[2] = 16'(a2); w[3] = 16'(a3); w[4] = 16'(a4);
    w[5] = 16'(a5); w[6] = 16'(a6); w[7] = 16'(a7); w[8] = 16'(a8);
    return w;
  endfunction

  // Reference: plain bubble sort, then rank / adaptive selection.
  task automatic model(input win_t px, input logic [3:0] r, output logic [15:0] d, output logic n);
    logic [15:0] s [9];
    logic [15:0] t;
    int rr;
    for (int i = 0; i < 9; i++) s[i] = px[i];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    rr = (r > 4'd8) ? 8 : int'(r);
    if (ADP) begin
      n = (px[4] == s[0]) || (px[4] == s[8]);
      d = n ? s[rr] : px[4];
    end else begin
      n = 1'b0;
      d = s[rr];
    end
  endtask

  task automatic send(input bit w, input win_t px, input logic [3:0] r,
                      input logic [15:0] ed, input logic en, input bit lat);
    exp_t e;
    if (!w) begin
      b8.in_valid = 1'b1; b8.rank_sel = r;
      for (int i = 0; i < 9; i++) b8.px_in[i*8 +: 8] = px[i][7:0];
    end else begin
      b12.in_valid = 1'b1; b12.rank_sel = r;
      for (int i = 0; i < 9; i++) b12.px_in[i*12 +: 12] = px[i][11:0];
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((!w && b8.in_ready) || (w && b12.in_ready)) begin
        e.d = ed; e.n = en; e.acc = cyc + 1; e.lat = lat;
        if (!w) q8.push_back(e); else q12.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic send_rand(input bit w, input bit lat);
    win_t px;
    logic [3:0] r;
    logic [15:0] d;
    logic n;
    for (int i = 0; i < 9; i++) px[i] = 16'($urandom_range(0, w ? 4095 : 255));
    r = 4'($urandom_range(0, 15));
    model(px, r, d, n);
    send(w, px, r, d, n, lat);
  endtask

  task automatic idle(input int n);
    b8.in_valid  = 1'b0;
    b12.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    idle(1);
    for (int k = 0; k < 100; k++) begin
      if (q8.size() == 0 && q12.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", q8.size() + q12.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) chk("out8_unexpected", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("out8_data", b8.out_data, e8.d);
        chk("out8_noisy", b8.out_noisy, e8.n);
        if (e8.lat) chk("out8_latency", cyc, e8.acc + 10);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b12.out_valid && b12.out_ready) begin
      if (q12.size() == 0) chk("out12_unexpected", 1, 0);
      else begin
        e12 = q12.pop_front();
        chk("out12_data", b12.out_data, e12.d);
        chk("out12_noisy", b12.out_noisy, e12.n);
        if (e12.lat) chk("out12_latency", cyc, e12.acc + 10);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    vec_t t12 [3];
    win_t wa, wb, wc, wx, w12;
    win_t hold_px;
    logic [15:0] hd;
    logic hn;

    wa  = mkw(9, 8, 7, 6, 5, 4, 3, 2, 1);
    wb  = mkw(10, 12, 255, 11, 0, 13, 14, 12, 11);
    wc  = mkw(10, 12, 20, 11, 15, 13, 14, 12, 11);
    wx  = mkw(255, 0, 255, 0, 128, 0, 255, 0, 255);
    w12 = mkw(4095, 4000, 12, 3000, 2048, 1, 4094, 7, 100);
    tbl[0] = '{wa, 4'd4,  16'd5,                1'b0};
    tbl[1] = '{wa, 4'd0,  ADP ? 16'd5 : 16'd1, 1'b0};
    tbl[2] = '{wa, 4'd8,  ADP ? 16'd5 : 16'd9, 1'b0};
    tbl[3] = '{wa, 4'd13, ADP ? 16'd5 : 16'd9, 1'b0};
    tbl[4] = '{wb, 4'd4,  16'd12,               ADP};
    tbl[5] = '{wc, 4'd4,  ADP ? 16'd15 : 16'd12, 1'b0};
    tbl[6] = '{mkw(7, 7, 7, 7, 7, 7, 7, 7, 7), 4'd0, 16'd7, ADP};
    tbl[7] = '{wx, 4'd4,  16'd128,              1'b0};
    t12[0] = '{w12, 4'd4,  16'd2048,                 1'b0};
    t12[1] = '{w12, 4'd15, ADP ? 16'd2048 : 16'd4095, 1'b0};
    t12[2] = '{w12, 4'd0,  ADP ? 16'd2048 : 16'd1,    1'b0};

    b8.in_valid = 1'b0;  b8.px_in = '0;  b8.rank_sel = '0;  b8.out_ready = 1'b1;
    b12.in_valid = 1'b0; b12.px_in = '0; b12.rank_sel = '0; b12.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_rst", b8.in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_out_data", b8.out_data, 0);
    chk("rst_out_noisy", b8.out_noisy, 0);
    chk("rst_in_ready", b8.in_ready, 1);
    chk("rst_out_valid12", b12.out_valid, 0);
    @(posedge clk); #1;

    // Directed table, back-to-back
    for (int i = 0; i < 8; i++) send(1'b0, tbl[i].px, tbl[i].r, tbl[i].d, tbl[i].n, 1'b1);
    drain();

    // Reset with 5 windows in flight
    for (int i = 0; i < 5; i++) send_rand(1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    chk("midrst_out_valid", b8.out_valid, 0);
    chk("midrst_in_ready", b8.in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    idle(15);
    chk("midrst_no_output", q8.size(), 0);

    // 20 back-to-back random windows
    for (int i = 0; i < 20; i++) send_rand(1'b0, 1'b1);
    drain();

    // Bubbles: valid 1,0,1,0,...
    for (int i = 0; i < 4; i++) begin
      send_rand(1'b0, 1'b1);
      idle(1);
    end
    drain();

    // Fill pipeline with sink stalled, hold 7 cycles, then release
    b8.out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_rand(1'b0, 1'b0);
    hold_px = mkw(3, 200, 45, 0, 99, 250, 17, 64, 128);
    model(hold_px, 4'd4, hd, hn);
    b8.in_valid = 1'b1;
    for (int i = 0; i < 9; i++) b8.px_in[i*8 +: 8] = hold_px[i][7:0];
    b8.rank_sel = 4'd4;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("stall_in_ready", b8.in_ready, 0);
      chk("stall_out_valid", b8.out_valid, 1);
      chk("stall_out_data", b8.out_data, q8[0].d);
      chk("stall_out_noisy", b8.out_noisy, q8[0].n);
      @(posedge clk); #1;
    end
    b8.out_ready = 1'b1;
    send(1'b0, hold_px, 4'd4, hd, hn, 1'b0);
    drain();
    chk("stall_q_empty", q8.size(), 0);

    // 12-bit instance: directed vectors then random back-to-back
    for (int i = 0; i < 3; i++) send(1'b1, t12[i].px, t12[i].r, t12[i].d, t12[i].n, 1'b1);
    send(1'b1, wa, 4'd4, 16'd5, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) send_rand(1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
